i2s_rx_deser: RTL and testbench

Serial-to-parallel I2S receiver front-end (Philips format) running in the serial-clock domain. It tracks WS transitions, shifts SD MSB-first into per-channel words, and presents completed left/right pairs on a valid/ready output. The output feeds the parallel write side of the receive buffering. It is the receive-side counterpart of the transmit serializer path.

---
 rtl/ctrl_pkg.sv | 23 ++
 rtl/ws_edge_det.sv | 23 ++
 rtl/i2s_rx_deser.sv | 142 ++++++++++++++
 tb/tb_i2s_rx_deser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S receive path and its FIFO control record.
package ctrl_pkg;

    typedef enum logic {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    typedef logic [1:0] rxd_state_t;

    localparam rxd_state_t IDLE  = 2'd0;
    localparam rxd_state_t SHIFT = 2'd1;
    localparam rxd_state_t PAD   = 2'd2;

    localparam logic [4:0] MAXP16 = 5'd15;
    localparam logic [4:0] MAXP32 = 5'd31;

    // Index of the last bit of a word: the bit counter reload value.
    function automatic logic [4:0] maxp_of(input frame_size_t fs);
        return (fs == f32bits) ? MAXP32 : MAXP16;
    endfunction

endpackage

// File: rtl/ws_edge_det.sv
// Word-select transition detector. ws_edge is high during the SCK cycle in
// which ws differs from its value at the previous posedge.
module ws_edge_det (
    input  logic clk,
    input  logic rst_,
    input  logic ws,
    output logic ws_edge
);

    logic ws_q;

    // Remember ws from the previous bit clock.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ws_q <= 1'b0;
        end else begin
            ws_q <= ws;
        end
    end

    assign ws_edge = (ws != ws_q);

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S (Philips) receive deserializer: collects MSB-first words per channel
// and presents left/right pairs on a valid/ready interface.
//
// state | meaning
// IDLE  | disabled or waiting for the first WS transition
// SHIFT | capturing word bits, cnt counts down to the LSB
// PAD   | word done, ignoring slot padding until the next WS transition
module i2s_rx_deser
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  frame_size_t      frame_size,
    input  logic             ws,
    input  logic             sd,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_left,
    output logic [WIDTH-1:0] out_right,
    output logic             frame_err,
    output logic             overrun
);

    rxd_state_t  state;
    logic [4:0]  cnt;
    logic [4:0]  maxp;
    logic        chan;
    logic        have_left;
    logic [30:0] shreg;
    logic [31:0] word_next;
    logic [31:0] left_word;
    logic        ws_edge;
    logic        pair_new;

    ws_edge_det u_ws_edge_det (
        .clk     (clk),
        .rst_    (rst_),
        .ws      (ws),
        .ws_edge (ws_edge)
    );

    // The shift register is cleared at every word start, so short words
    // come out zero-extended without masking.
    assign word_next = {shreg, sd};
    assign maxp      = maxp_of(frame_size);
    assign pair_new  = en && (state == SHIFT) && (cnt == 5'd0) && chan && have_left;

    // Bit capture state machine.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            chan      <= 1'b0;
            shreg     <= '0;
            have_left <= 1'b0;
            left_word <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                cnt       <= 5'd0;
                shreg     <= '0;
                have_left <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ws_edge) begin
                            state <= SHIFT;
                            cnt   <= maxp;
                            chan  <= ws;
                            shreg <= '0;
                        end
                    end
                    SHIFT: begin
                        if (cnt == 5'd0) begin
                            if (!chan) begin
                                left_word <= word_next;
                                have_left <= 1'b1;
                            end else begin
                                have_left <= 1'b0;
                            end
                            if (ws_edge) begin
                                cnt   <= maxp;
                                chan  <= ws;
                                shreg <= '0;
                            end else begin
                                state <= PAD;
                            end
                        end else if (ws_edge) begin
                            frame_err <= 1'b1;
                            have_left <= 1'b0;
                            cnt       <= maxp;
                            chan      <= ws;
                            shreg     <= '0;
                        end else begin
                            shreg <= word_next[30:0];
                            cnt   <= cnt - 5'd1;
                        end
                    end
                    PAD: begin
                        if (ws_edge) begin
                            state <= SHIFT;
                            cnt   <= maxp;
                            chan  <= ws;
                            shreg <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output pair register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            overrun   <= 1'b0;
        end else begin
            if (pair_new && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_left  <= WIDTH'(left_word);
                out_right <= WIDTH'(word_next);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (pair_new && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
`timescale 1ns/1ps
module tb_i2s_rx_deser;
    import ctrl_pkg::*;

    localparam int WIDTH = 32;
    localparam int MAXC  = 1024;

    logic             clk = 1'b0;
    logic             rst_ = 1'b1;
    logic             en = 1'b0;
    frame_size_t      frame_size = f32bits;
    logic             ws = 1'b0;
    logic             sd = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_ovr = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_left;
    logic [WIDTH-1:0] out_right;
    logic             frame_err;
    logic             overrun;

    int checks = 0;
    int failures = 0;

    i2s_rx_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .en         (en),
        .frame_size (frame_size),
        .ws         (ws),
        .sd         (sd),
        .out_ready  (out_ready),
        .clr_ovr    (clr_ovr),
        .out_valid  (out_valid),
        .out_left   (out_left),
        .out_right  (out_right),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Per-cycle stimulus and expected word-level events.
    bit          ws_a[MAXC], sd_a[MAXC], en_a[MAXC], rdy_a[MAXC], clr_a[MAXC], fs32_a[MAXC];
    bit          err_e[MAXC], pair_e[MAXC];
    logic [31:0] l_e[MAXC], r_e[MAXC];
    int          n_cyc;
    int          rst_at;
    int          slot_len[$];
    logic [31:0] slot_word[$];

    // Expected output-side state.
    bit          mv, movr;
    logic [31:0] ml, mr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cyc(input int t, input bit wsv, input bit env, input int rdy_pct, input bit clr_rand);
        ws_a[t]   = wsv;
        en_a[t]   = env;
        sd_a[t]   = 1'($urandom);
        fs32_a[t] = 1'($urandom);
        rdy_a[t]  = ($urandom_range(99) < rdy_pct);
        clr_a[t]  = clr_rand && ($urandom_range(15) == 0);
        err_e[t]  = 1'b0;
        pair_e[t] = 1'b0;
        l_e[t]    = '0;
        r_e[t]    = '0;
    endtask

    // Build a serial stream from slot_len/slot_word and derive the expected
    // word events from the slot layout: a slot at least nbits long yields a
    // word whose LSB lands nbits SCKs after the slot's WS transition; a
    // shorter slot is a framing error.
    task automatic build(input int nbits, input bit ws0, input int rst_slot,
                         input int rdy_pct, input bit clr_rand);
        int          cur, st, len;
        bit          hl, wsk;
        logic [31:0] w, lw;
        cur = 0;
        rst_at = -1;
        for (int i = 0; i < 4; i++) begin
            set_cyc(cur, !ws0, 1'b0, rdy_pct, clr_rand);
            cur++;
        end
        for (int k = 0; k < slot_len.size(); k++) begin
            st = cur;
            for (int j = 0; j < slot_len[k]; j++) begin
                set_cyc(cur, ws0 ^ k[0], 1'b1, rdy_pct, clr_rand);
                cur++;
            end
            fs32_a[st] = (nbits == 32);
        end
        for (int j = 0; j < 40; j++) begin
            set_cyc(cur, ws_a[cur-1], 1'b1, rdy_pct, clr_rand);
            cur++;
        end
        n_cyc = cur;

        cur = 4;
        hl = 1'b0;
        lw = '0;
        for (int k = 0; k < slot_len.size(); k++) begin
            st  = cur;
            len = slot_len[k];
            wsk = ws0 ^ k[0];
            w   = (nbits == 16) ? {16'h0, slot_word[k][15:0]} : slot_word[k];
            for (int i = 0; i < nbits; i++) begin
                if (i < len) sd_a[st + 1 + i] = w[nbits - 1 - i];
            end
            if (k == rst_slot) begin
                rst_at = st + 5;
                hl = 1'b0;
            end else if (len < nbits) begin
                err_e[st + len] = 1'b1;
                hl = 1'b0;
            end else if (!wsk) begin
                hl = 1'b1;
                lw = w;
            end else if (hl) begin
                pair_e[st + nbits] = 1'b1;
                l_e[st + nbits] = lw;
                r_e[st + nbits] = w;
                hl = 1'b0;
            end
            cur += len;
        end
    endtask

    task automatic run();
        bit set_o;
        for (int t = 0; t < n_cyc; t++) begin
            @(negedge clk);
            ws         = ws_a[t];
            sd         = sd_a[t];
            en         = en_a[t];
            out_ready  = rdy_a[t];
            clr_ovr    = clr_a[t];
            frame_size = fs32_a[t] ? f32bits : f16bits;
            if (t == rst_at) begin
                #1 rst_ = 1'b0;
                #1;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_left", out_left, 0);
                chk("rst_out_right", out_right, 0);
                chk("rst_overrun", overrun, 0);
                chk("rst_frame_err", frame_err, 0);
                mv = 1'b0; movr = 1'b0; ml = '0; mr = '0;
                #1 rst_ = 1'b1;
            end
            @(posedge clk);
            #1;
            set_o = 1'b0;
            if (pair_e[t]) begin
                if (!mv || out_ready) begin
                    mv = 1'b1; ml = l_e[t]; mr = r_e[t];
                end else begin
                    set_o = 1'b1;
                end
            end else if (mv && out_ready) begin
                mv = 1'b0;
            end
            if (set_o) movr = 1'b1;
            else if (clr_ovr) movr = 1'b0;
            chk("frame_err", frame_err, err_e[t]);
            chk("out_valid", out_valid, mv);
            chk("overrun", overrun, movr);
            if (mv) begin
                chk("out_left", out_left, ml);
                chk("out_right", out_right, mr);
            end
        end
    endtask

    initial begin
        int nb, len, sel;
        mv = 1'b0; movr = 1'b0; ml = '0; mr = '0;
        #1 rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_left", out_left, 0);
        chk("reset_out_right", out_right, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        @(negedge clk);
        rst_ = 1'b1;

        // 32-bit words, 64-SCK WS period.
        slot_len  = {32, 32};
        slot_word = {32'hA5A5_0001, 32'h8000_00FF};
        build(32, 1'b0, -1, 100, 1'b0);
        run();

        // 16-bit words, 16-SCK slots.
        slot_len  = {16, 16};
        slot_word = {32'h0000_1234, 32'h0000_FEDC};
        build(16, 1'b0, -1, 100, 1'b0);
        run();

        // 16-bit words in 32-SCK slots: trailing padding ignored.
        slot_len  = {32, 32, 32, 32};
        slot_word = {$urandom, $urandom, $urandom, $urandom};
        build(16, 1'b0, -1, 100, 1'b0);
        run();

        // Short right word after 20 bits, then a full pair.
        slot_len  = {32, 20, 32, 32};
        slot_word = {$urandom, $urandom, $urandom, $urandom};
        build(32, 1'b0, -1, 100, 1'b0);
        run();

        // Two pairs with no consumer: overrun, clear, then deliver held pair.
        slot_len  = {32, 32, 32, 32};
        slot_word = {$urandom, $urandom, $urandom, $urandom};
        build(32, 1'b0, -1, 0, 1'b0);
        clr_a[n_cyc - 10] = 1'b1;
        rdy_a[n_cyc - 5]  = 1'b1;
        run();

        // Reset in the middle of a left word.
        slot_len  = {32, 32, 32, 32, 32, 32};
        slot_word = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        build(32, 1'b0, 2, 100, 1'b0);
        run();

        // Randomized streams: word size, slot lengths, backpressure, clears.
        for (int s = 0; s < 6; s++) begin
            nb = ($urandom_range(1) == 1) ? 32 : 16;
            slot_len.delete();
            slot_word.delete();
            for (int k = 0; k < 6; k++) begin
                sel = $urandom_range(9);
                if (sel < 5)      len = nb;
                else if (sel < 8) len = nb + $urandom_range(1, 12);
                else              len = $urandom_range(2, nb - 1);
                slot_len.push_back(len);
                slot_word.push_back($urandom);
            end
            build(nb, 1'($urandom), -1, 70, 1'b1);
            run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
